// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
//
// Registered immediate-generation stage that sits between the instruction-fetch
// register and the ID/EX operand mux. Each incoming MIPS instruction is
// classified by opcode into an extension mode. The 32-bit immediate is
// computed combinationally on the input side and stored with the instruction
// when the instruction is accepted. A 2-entry buffer (output register plus one
// skid entry) gives full throughput. It also keeps in_ready free of any
// combinational path from out_ready.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The source holds its payload stable while valid=1 and ready=0.
// The source never withdraws valid before the transfer, except on flush.
// While out_valid=1 and out_ready=0, out_* do not change.
//
// Parameters:
//   BRANCH_SHIFT  1: branch imm = sext(imm16)<<2, 0: sext(imm16)
//   JUMP_SHIFT    1: jump imm = {4'b0, idx26, 2'b00}, 0: {6'b0, idx26}
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous flush; drops both entries and any same-cycle input
//   in_valid   upstream instruction valid
//   in_ready   stage can accept an instruction (registered)
//   in_instr   instruction word
//   out_valid  output entry valid
//   out_ready  downstream accepts
//   out_instr  instruction passed through
//   out_imm    generated immediate
//   out_mode   extension mode code (0 NONE .. 6 SHAMT)
// -----------------------------------------------------------------------------
module imm_gen_stage #(
   parameter bit BRANCH_SHIFT = 1'b1,
   parameter bit JUMP_SHIFT   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_imm,
   output logic [2:0]  out_mode
);

   localparam logic [2:0] MODE_NONE   = 3'd0;
   localparam logic [2:0] MODE_ZERO16 = 3'd1;
   localparam logic [2:0] MODE_SIGN16 = 3'd2;
   localparam logic [2:0] MODE_LUI    = 3'd3;
   localparam logic [2:0] MODE_BRANCH = 3'd4;
   localparam logic [2:0] MODE_JUMP   = 3'd5;
   localparam logic [2:0] MODE_SHAMT  = 3'd6;

   // ---------------------------------------------------------------------------
   // Input-side decode
   // ---------------------------------------------------------------------------
   logic [5:0]  opcode;
   logic [15:0] imm16;
   logic [31:0] sext16;
   logic [31:0] dec_imm;
   logic [2:0]  dec_mode;

   assign opcode = in_instr[31:26];
   assign imm16  = in_instr[15:0];
   assign sext16 = {{16{imm16[15]}}, imm16};

   always_comb begin
      dec_imm  = 32'h0000_0000;
      dec_mode = MODE_NONE;
      case (opcode)
         6'h0C, 6'h0D, 6'h0E: begin
            dec_mode = MODE_ZERO16;
            dec_imm  = {16'h0000, imm16};
         end
         6'h08, 6'h09, 6'h0A, 6'h0B,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
         6'h26, 6'h27, 6'h28, 6'h29, 6'h2A, 6'h2B: begin
            dec_mode = MODE_SIGN16;
            dec_imm  = sext16;
         end
         6'h0F: begin
            dec_mode = MODE_LUI;
            dec_imm  = {imm16, 16'h0000};
         end
         6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
            dec_mode = MODE_BRANCH;
            if (BRANCH_SHIFT) begin
               dec_imm = {sext16[29:0], 2'b00};
            end else begin
               dec_imm = sext16;
            end
         end
         6'h02, 6'h03: begin
            dec_mode = MODE_JUMP;
            if (JUMP_SHIFT) begin
               dec_imm = {4'b0000, in_instr[25:0], 2'b00};
            end else begin
               dec_imm = {6'b000000, in_instr[25:0]};
            end
         end
         6'h00: begin
            dec_mode = MODE_SHAMT;
            dec_imm  = {27'h0, in_instr[10:6]};
         end
         default: begin
            dec_mode = MODE_NONE;
            dec_imm  = 32'h0000_0000;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output register + skid entry
   // ---------------------------------------------------------------------------
   logic        skid_valid;
   logic [31:0] skid_instr;
   logic [31:0] skid_imm;
   logic [2:0]  skid_mode;
   logic        accept;
   logic        out_free;

   // in_ready comes straight from the skid flag, so out_ready never reaches it
   // combinationally. When the skid holds an entry, the output is full, so
   // nothing new is taken.
   assign in_ready = ~skid_valid;
   assign accept   = in_valid & in_ready;
   // The output register can be written when it is empty or draining now.
   assign out_free = ~out_valid | out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_instr  <= 32'h0000_0000;
         out_imm    <= 32'h0000_0000;
         out_mode   <= MODE_NONE;
         skid_valid <= 1'b0;
         skid_instr <= 32'h0000_0000;
         skid_imm   <= 32'h0000_0000;
         skid_mode  <= MODE_NONE;
      end else if (flush) begin
         // Data registers keep stale contents; the valid flags hide them.
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (out_free) begin
         if (skid_valid) begin
            // The older skid entry goes first. in_ready was low, so no new
            // input competes with it.
            out_valid  <= 1'b1;
            out_instr  <= skid_instr;
            out_imm    <= skid_imm;
            out_mode   <= skid_mode;
            skid_valid <= 1'b0;
         end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= in_instr;
            out_imm   <= dec_imm;
            out_mode  <= dec_mode;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         // The output is held by backpressure, so the new entry parks in the skid.
         skid_valid <= 1'b1;
         skid_instr <= in_instr;
         skid_imm   <= dec_imm;
         skid_mode  <= dec_mode;
      end
   end

endmodule

// File: tb/tb_imm_gen_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_stage
//
// Bench for imm_gen_stage. Two instances share every input: dut uses the
// default shifts, and dut_ns sets BRANCH_SHIFT=0 and JUMP_SHIFT=0. Expected
// entries are pushed by the driver at the moment an accept is known to
// happen. They are popped by a negedge monitor on every output transfer.
// -----------------------------------------------------------------------------
module tb_imm_gen_stage;

   // ---------------------------------------------------------------- clock/reset
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = 32'h0;
   logic        out_ready = 1'b0;

   logic        in_ready, in_ready_ns;
   logic        out_valid, out_valid_ns;
   logic [31:0] out_instr, out_instr_ns;
   logic [31:0] out_imm, out_imm_ns;
   logic [2:0]  out_mode, out_mode_ns;

   always #5 clk = ~clk;

   imm_gen_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_imm(out_imm), .out_mode(out_mode)
   );

   imm_gen_stage #(.BRANCH_SHIFT(1'b0), .JUMP_SHIFT(1'b0)) dut_ns (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_ns), .in_instr(in_instr),
      .out_valid(out_valid_ns), .out_ready(out_ready),
      .out_instr(out_instr_ns), .out_imm(out_imm_ns), .out_mode(out_mode_ns)
   );

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   // Returns {mode[2:0], imm[31:0]}.
   function automatic logic [34:0] model(input logic [31:0] ins, input bit bsh, input bit jsh);
      logic [5:0]  op;
      logic [31:0] s;
      op = ins[31:26];
      s  = {{16{ins[15]}}, ins[15:0]};
      if (op == 6'd0)
         return {3'd6, 27'd0, ins[10:6]};
      else if (op inside {6'h0C, 6'h0D, 6'h0E})
         return {3'd1, 16'd0, ins[15:0]};
      else if (op inside {[6'h08:6'h0B], [6'h20:6'h2B]})
         return {3'd2, s};
      else if (op == 6'h0F)
         return {3'd3, ins[15:0], 16'd0};
      else if (op inside {6'h01, [6'h04:6'h07]})
         return {3'd4, bsh ? (s << 2) : s};
      else if (op inside {6'h02, 6'h03})
         return {3'd5, jsh ? {4'd0, ins[25:0], 2'd0} : {6'd0, ins[25:0]}};
      else
         return {3'd0, 32'd0};
   endfunction

   // ---------------------------------------------------------------- scoreboard
   // Entry layout: {instr[31:0], imm_shift[31:0], imm_noshift[31:0], mode[2:0]}
   logic [98:0] exp_q[$];
   logic [98:0] sb_e;

   task automatic push_exp(input logic [31:0] ins);
      logic [34:0] a, b;
      a = model(ins, 1'b1, 1'b1);
      b = model(ins, 1'b0, 1'b0);
      exp_q.push_back({ins, a[31:0], b[31:0], a[34:32]});
   endtask

   always @(negedge clk) begin
      if (rst_n && !flush && out_valid && out_ready) begin
         check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            sb_e = exp_q.pop_front();
            check("sb_instr", out_instr, sb_e[98:67]);
            check("sb_imm", out_imm, sb_e[66:35]);
            check("sb_mode", 32'(out_mode), 32'(sb_e[2:0]));
            check("sb_ns_valid", 32'(out_valid_ns), 32'd1);
            check("sb_ns_instr", out_instr_ns, sb_e[98:67]);
            check("sb_ns_imm", out_imm_ns, sb_e[34:3]);
            check("sb_ns_mode", 32'(out_mode_ns), 32'(sb_e[2:0]));
            check("sb_ns_ready", 32'(in_ready_ns), 32'(in_ready));
         end
      end
   end

   // ---------------------------------------------------------------- driver tasks
   // Call away from a clock edge. Returns 1 time unit after the accepting edge.
   task automatic send(input logic [31:0] ins);
      bit done;
      done = 1'b0;
      in_valid = 1'b1;
      in_instr = ins;
      for (int i = 0; i < 50 && !done; i++) begin
         if (in_ready) begin
            push_exp(ins);
            @(posedge clk);
            #1;
            done = 1'b1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
      if (!done) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_valid", 32'(out_valid), 32'd0);
   endtask

   // Directed vectors: instr, imm (shifted), imm (unshifted), mode.
   logic [31:0] vec_instr [8] = '{32'h34228001, 32'h20228001, 32'h3C011234, 32'h1022FFFF,
                                  32'h08000010, 32'h00021100, 32'hFC000000, 32'h40000000};
   logic [31:0] vec_imm   [8] = '{32'h00008001, 32'hFFFF8001, 32'h12340000, 32'hFFFFFFFC,
                                  32'h00000040, 32'h00000004, 32'h00000000, 32'h00000000};
   logic [31:0] vec_imm_ns[8] = '{32'h00008001, 32'hFFFF8001, 32'h12340000, 32'hFFFFFFFF,
                                  32'h00000010, 32'h00000004, 32'h00000000, 32'h00000000};
   logic [2:0]  vec_mode  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0};

   logic [31:0] op_a, op_b, op_c, op_d;
   bit          rnd_done;

   // ---------------------------------------------------------------- main sequence
   initial begin
      op_a = 32'h3401_00AA;
      op_b = 32'h2401_8000;
      op_c = 32'h1000_0003;
      op_d = 32'h0C00_0123;

      // Reset state.
      #2;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_instr", out_instr, 32'd0);
      check("rst_imm", out_imm, 32'd0);
      check("rst_mode", 32'(out_mode), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);

      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Back-to-back directed vectors with one-cycle latency.
      check("lat_pre_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         send(vec_instr[i]);
         check("vec_valid", 32'(out_valid), 32'd1);
         check("vec_instr", out_instr, vec_instr[i]);
         check("vec_imm", out_imm, vec_imm[i]);
         check("vec_imm_ns", out_imm_ns, vec_imm_ns[i]);
         check("vec_mode", 32'(out_mode), 32'(vec_mode[i]));
      end
      drain();

      // Backpressure: A held on the output, B in the skid, C waiting upstream.
      out_ready = 1'b0;
      send(op_a);
      check("bp_ready_a", 32'(in_ready), 32'd1);
      send(op_b);
      check("bp_ready_drop", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_instr = op_c;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_instr", out_instr, op_a);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_out_a", out_instr, op_a);
      @(posedge clk);
      #1;
      check("bp_out_b", out_instr, op_b);
      check("bp_ready_back", 32'(in_ready), 32'd1);
      push_exp(op_c);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_out_c", out_instr, op_c);
      check("bp_out_c_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      check("bp_empty", 32'(out_valid), 32'd0);

      // Flush with both entries full and an input pending.
      out_ready = 1'b0;
      send(op_a);
      send(op_b);
      in_valid = 1'b1;
      in_instr = op_d;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      check("fl_full_valid", 32'(out_valid), 32'd0);
      check("fl_full_ready", 32'(in_ready), 32'd1);

      // Flush overrides an accept that would otherwise land in the skid.
      send(op_a);
      in_valid = 1'b1;
      in_instr = op_d;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      check("fl_acc_valid", 32'(out_valid), 32'd0);
      check("fl_acc_ready", 32'(in_ready), 32'd1);
      drain();

      // Random traffic with random backpressure.
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               send($urandom);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();

      // Asynchronous reset with both entries full.
      out_ready = 1'b0;
      send(op_a);
      send(op_b);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_instr", out_instr, 32'd0);
      check("arst_imm", out_imm, 32'd0);
      check("arst_mode", 32'(out_mode), 32'd0);
      check("arst_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      out_ready = 1'b1;
      check("arst_rel_valid", 32'(out_valid), 32'd0);
      send(op_c);
      check("arst_first_valid", 32'(out_valid), 32'd1);
      check("arst_first_instr", out_instr, op_c);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
